// File: rtl/axi_stream_proc_fifo.sv
// axi_stream_proc_fifo
//   AXI-Stream FIFO that transforms tdata as each beat is written.
//   The transform (pass / byte-reverse / add / xor) and its operand are
//   sampled on the head beat of a packet and held until its tlast beat.
//
// Parameters
//   DATA_WIDTH  stream data width, multiple of 8 (8..512)
//   DEPTH       number of entries, power of two (2..256)
//
// Ports
//   aclk, areset            clock, asynchronous active-low reset
//   mode, add_value         transform select and operand
//   s_axis_*                input stream (tdata/tkeep/tstrb/tlast/tvalid/tready)
//   m_axis_*                output stream (tdata/tkeep/tstrb/tlast/tvalid/tready)
//   fill_level              stored beats, 0..DEPTH
//   pkt_count, drop_stall   statistics, present only with AXIS_PROC_STATS_EN
//
// Optional feature macro: AXIS_PROC_STATS_EN
module axi_stream_proc_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned BYTES     = DATA_WIDTH / 8,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] add_value,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [BYTES-1:0]      s_axis_tkeep,
    input  logic [BYTES-1:0]      s_axis_tstrb,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [BYTES-1:0]      m_axis_tkeep,
    output logic [BYTES-1:0]      m_axis_tstrb,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [AW:0]           fill_level
`ifdef AXIS_PROC_STATS_EN
    ,
    output logic [31:0]           pkt_count,
    output logic [31:0]           drop_stall
`endif
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                 state, state_next;
    logic [1:0]             mode_q;
    logic [DATA_WIDTH-1:0]  add_q;
    logic [1:0]             mode_eff;
    logic [DATA_WIDTH-1:0]  add_eff;
    logic [DATA_WIDTH-1:0]  data_rev;
    logic [DATA_WIDTH-1:0]  data_xf;

    logic [DATA_WIDTH-1:0]  mem_data [DEPTH];
    logic [BYTES-1:0]       mem_keep [DEPTH];
    logic [BYTES-1:0]       mem_strb [DEPTH];
    logic                   mem_last [DEPTH];

    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   wr_en, rd_en;

    assign s_axis_tready = (count != FULL);
    assign m_axis_tvalid = (count != '0);
    assign fill_level    = count;
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign rd_en         = m_axis_tvalid && m_axis_tready;

    // A head beat uses the live mode/operand; later beats use the copy
    // latched when that head beat was accepted.
    assign mode_eff = (state == IDLE) ? mode      : mode_q;
    assign add_eff  = (state == IDLE) ? add_value : add_q;

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state  <= IDLE;
            mode_q <= '0;
            add_q  <= '0;
        end else begin
            state <= state_next;
            if (wr_en && state == IDLE) begin
                mode_q <= mode;
                add_q  <= add_value;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr_en && !s_axis_tlast) state_next = IN_PKT;
            IN_PKT:  if (wr_en &&  s_axis_tlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_rev = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            data_rev[8*(BYTES-1-i) +: 8] = s_axis_tdata[8*i +: 8];
        end
    end

    always_comb begin
        data_xf = s_axis_tdata;
        case (mode_eff)
            2'd1:    data_xf = data_rev;
            2'd2:    data_xf = s_axis_tdata + add_eff;
            2'd3:    data_xf = s_axis_tdata ^ add_eff;
            default: data_xf = s_axis_tdata;
        endcase
    end

    // Storage is not reset; fill_level alone says which entries are live.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= data_xf;
            mem_keep[wr_ptr] <= s_axis_tkeep;
            mem_strb[wr_ptr] <= s_axis_tstrb;
            mem_last[wr_ptr] <= s_axis_tlast;
        end
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        m_axis_tstrb = '0;
        m_axis_tlast = 1'b0;
        if (m_axis_tvalid) begin
            m_axis_tdata = mem_data[rd_ptr];
            m_axis_tkeep = mem_keep[rd_ptr];
            m_axis_tstrb = mem_strb[rd_ptr];
            m_axis_tlast = mem_last[rd_ptr];
        end
    end

`ifdef AXIS_PROC_STATS_EN
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            pkt_count  <= '0;
            drop_stall <= '0;
        end else begin
            if (rd_en && m_axis_tlast)          pkt_count  <= pkt_count + 32'd1;
            if (s_axis_tvalid && !s_axis_tready) drop_stall <= drop_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_stream_proc_fifo.sv
module tb_axi_stream_proc_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          aclk;
    logic          areset;
    logic [1:0]    mode;
    logic [31:0]   add_value;
    logic [31:0]   s_tdata;
    logic [3:0]    s_tkeep, s_tstrb;
    logic          s_tlast, s_tvalid, s_tready;
    logic [31:0]   m_tdata;
    logic [3:0]    m_tkeep, m_tstrb;
    logic          m_tlast, m_tvalid, m_tready;
    logic [4:0]    fill_level;

    // 64-bit instance for the wide byte-reverse case
    logic [1:0]    mode64;
    logic [63:0]   s64_tdata, m64_tdata;
    logic [7:0]    s64_tkeep, m64_tkeep, m64_tstrb;
    logic          s64_tvalid, s64_tready, m64_tlast, m64_tvalid;
    logic [3:0]    fill64;

`ifdef AXIS_PROC_STATS_EN
    logic [31:0]   pkt_count, drop_stall, pkt64, stall64;
`endif

    axi_stream_proc_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .areset(areset), .mode(mode), .add_value(add_value),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tstrb(s_tstrb),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tstrb(m_tstrb),
        .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .fill_level(fill_level)
`ifdef AXIS_PROC_STATS_EN
        , .pkt_count(pkt_count), .drop_stall(drop_stall)
`endif
    );

    axi_stream_proc_fifo #(.DATA_WIDTH(64), .DEPTH(8)) dut64 (
        .aclk(aclk), .areset(areset), .mode(mode64), .add_value(64'd0),
        .s_axis_tdata(s64_tdata), .s_axis_tkeep(s64_tkeep), .s_axis_tstrb(s64_tkeep),
        .s_axis_tlast(1'b1), .s_axis_tvalid(s64_tvalid), .s_axis_tready(s64_tready),
        .m_axis_tdata(m64_tdata), .m_axis_tkeep(m64_tkeep), .m_axis_tstrb(m64_tstrb),
        .m_axis_tlast(m64_tlast), .m_axis_tvalid(m64_tvalid), .m_axis_tready(1'b0),
        .fill_level(fill64)
`ifdef AXIS_PROC_STATS_EN
        , .pkt_count(pkt64), .drop_stall(stall64)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  s;
        logic        l;
    } beat_t;

    beat_t       q[$];
    bit          in_pkt;
    logic [1:0]  lmode;
    logic [31:0] ladd;
    logic [31:0] m_pkt, m_stall;

    function automatic logic [31:0] xform(logic [1:0] m, logic [31:0] d, logic [31:0] a);
        logic [31:0] r;
        case (m)
            2'd0: r = d;
            2'd1: begin
                r = '0;
                for (int i = 0; i < 4; i++) r[8*(3-i) +: 8] = d[8*i +: 8];
            end
            2'd2: r = d + a;
            default: r = d ^ a;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        in_pkt  = 0;
        lmode   = '0;
        ladd    = '0;
        m_pkt   = '0;
        m_stall = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("fill_level", 64'(fill_level), 64'(q.size()));
        chk("m_tvalid", 64'(m_tvalid), 64'(q.size() != 0));
        chk("s_tready", 64'(s_tready), 64'(q.size() != DEPTH));
        if (q.size() != 0) begin
            chk("m_tdata", 64'(m_tdata), 64'(q[0].d));
            chk("m_tkeep", 64'(m_tkeep), 64'(q[0].k));
            chk("m_tstrb", 64'(m_tstrb), 64'(q[0].s));
            chk("m_tlast", 64'(m_tlast), 64'(q[0].l));
        end else begin
            chk("m_data_zero", {m_tdata, 23'd0, m_tkeep, m_tstrb, m_tlast}, 64'd0);
        end
`ifdef AXIS_PROC_STATS_EN
        chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
        chk("drop_stall", 64'(drop_stall), 64'(m_stall));
`endif
    endtask

    // Check outputs mid-cycle, then advance model across the rising edge.
    task automatic tick();
        bit acc, cons;
        logic [1:0]  em;
        logic [31:0] ea;
        beat_t b;
        @(negedge aclk);
        check_outputs();
        @(posedge aclk);
        acc  = s_tvalid && (q.size() != DEPTH);
        cons = m_tready && (q.size() != 0);
        if (s_tvalid && !acc) m_stall++;
        if (cons) begin
            if (q[0].l) m_pkt++;
            void'(q.pop_front());
        end
        if (acc) begin
            em = in_pkt ? lmode : mode;
            ea = in_pkt ? ladd  : add_value;
            if (!in_pkt) begin
                lmode = mode;
                ladd  = add_value;
            end
            b.d = xform(em, s_tdata, ea);
            b.k = s_tkeep;
            b.s = s_tstrb;
            b.l = s_tlast;
            q.push_back(b);
            in_pkt = !s_tlast;
        end
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        s_tkeep  = 4'hF;
        s_tstrb  = 4'hF;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  mode;
        logic [31:0] add;
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'd0, 32'h0000_0000, 32'h1234_5678, 4'hF, 4'hF, 32'h1234_5678};
        vecs[1] = '{2'd1, 32'h0000_0000, 32'h1122_3344, 4'hF, 4'hF, 32'h4433_2211};
        vecs[2] = '{2'd1, 32'hDEAD_BEEF, 32'hA0B0_C0D0, 4'h3, 4'h1, 32'hD0C0_B0A0};
        vecs[3] = '{2'd2, 32'h0000_0002, 32'hFFFF_FFFF, 4'hF, 4'hF, 32'h0000_0001};
        vecs[4] = '{2'd2, 32'h0000_0001, 32'h7FFF_FFFF, 4'h7, 4'h6, 32'h8000_0000};
        vecs[5] = '{2'd3, 32'hF0F0_F0F0, 32'h1234_5678, 4'hF, 4'hF, 32'hE2C4_A688};
        vecs[6] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 4'h8, 4'h0, 32'hFFFF_FFFF};

        areset = 1'b0;
        mode = '0; add_value = '0;
        s_tdata = '0; s_tkeep = '0; s_tstrb = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        m_tready = 1'b0;
        mode64 = 2'd1; s64_tdata = '0; s64_tkeep = '0; s64_tvalid = 1'b0;
        model_reset();

        // reset state
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_s_tready", 64'(s_tready), 64'd1);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata",  64'(m_tdata),  64'd0);
        chk("rst_fill",     64'(fill_level), 64'd0);
        areset = 1'b1;
        tick();

        // 64-bit byte reverse
        s64_tdata = 64'h0102_0304_0506_0708; s64_tkeep = 8'hFF; s64_tvalid = 1'b1;
        tick();
        s64_tvalid = 1'b0;
        chk("w64_rev_data", m64_tdata, 64'h0807_0605_0403_0201);
        chk("w64_rev_keep", 64'(m64_tkeep), 64'hFF);

        // table of single-beat packets
        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].mode; add_value = vecs[i].add;
            s_tdata = vecs[i].data; s_tkeep = vecs[i].keep; s_tstrb = vecs[i].strb;
            s_tlast = 1'b1; s_tvalid = 1'b1;
            tick();
            s_tvalid = 1'b0;
            chk("vec_data", 64'(m_tdata), 64'(vecs[i].exp));
            chk("vec_keep", 64'(m_tkeep), 64'(vecs[i].keep));
            chk("vec_strb", 64'(m_tstrb), 64'(vecs[i].strb));
            m_tready = 1'b1;
            tick();
            m_tready = 1'b0;
        end

        // fill to DEPTH with m_tready low, then drain in order
        mode = 2'd0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            beat(32'(i), 1'b1);
            tick();
        end
        s_tvalid = 1'b0;
        chk("full_tready", 64'(s_tready), 64'd0);
        chk("full_fill", 64'(fill_level), 64'(DEPTH));
        m_tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 64'(m_tdata), 64'(i));
            tick();
        end
        chk("drain_empty", 64'(fill_level), 64'd0);

        // mode latched per packet: change mid-packet has no effect
        mode = 2'd2; add_value = 32'd2;
        beat(32'h10, 1'b0); tick();
        chk("pkt_b1", 64'(m_tdata), 64'h12);
        mode = 2'd0; add_value = 32'd100;
        beat(32'h20, 1'b0); tick();
        chk("pkt_b2", 64'(m_tdata), 64'h22);
        beat(32'h30, 1'b1); tick();
        chk("pkt_b3", 64'(m_tdata), 64'h32);
        beat(32'h40, 1'b1); tick();
        chk("pkt_next", 64'(m_tdata), 64'h40);
        s_tvalid = 1'b0;
        tick();

        // full FIFO with both sides streaming across pointer wrap
        m_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            beat(32'(100 + i), 1'b0); tick();
        end
        m_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            beat(32'(200 + i), 1'(i % 5 == 4)); tick();
        end
        s_tvalid = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) tick();

        // reset mid-packet with 5 beats stored
        m_tready = 1'b0;
        mode = 2'd3; add_value = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            beat(32'(i), 1'b0); tick();
        end
        s_tvalid = 1'b0;
        areset = 1'b0;
        #1;
        chk("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_mid_fill", 64'(fill_level), 64'd0);
        model_reset();
        @(posedge aclk); #1;
        areset = 1'b1;
        mode = 2'd1;
        beat(32'hCAFE_0001, 1'b1); tick();
        s_tvalid = 1'b0;
        chk("rst_head_mode", 64'(m_tdata), 64'h0100_FECA);
        m_tready = 1'b1;
        tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) add_value = $urandom;
            s_tdata  = $urandom;
            s_tkeep  = 4'($urandom);
            s_tstrb  = 4'($urandom);
            s_tlast  = ($urandom_range(0, 3) == 0);
            s_tvalid = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            m_tready = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();

`ifdef AXIS_PROC_STATS_EN
        // 3 packets consumed plus 4 stalled input cycles after reset
        areset = 1'b0; #1; model_reset();
        @(posedge aclk); #1;
        areset = 1'b1;
        m_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            beat(32'(i), 1'(i == 0 || i == 1 || i == 5)); tick();
        end
        for (int i = 0; i < 4; i++) tick();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        m_tready = 1'b0;
        chk("stats_pkts", 64'(pkt_count), 64'd3);
        chk("stats_stall", 64'(drop_stall), 64'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
